// File: rtl/regfile_ctrl_if.sv
// regfile_ctrl_if: instruction handshake and register-file port bundle for regfile_ctrl
interface regfile_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              instr_valid;
  logic              instr_ready;
  logic [7:0]        instr;
  logic [DATA_W-1:0] imm;
  logic [ADDR_W-1:0] RA1;
  logic [ADDR_W-1:0] RA2;
  logic [ADDR_W-1:0] RA3;
  logic [DATA_W-1:0] WD3;
  logic              WE3;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              carry;
  logic              done;
  modport master (
    output instr_valid, instr, imm, RD1, RD2,
    input  instr_ready, RA1, RA2, RA3, WD3, WE3, result, zero, carry, done
  );
  modport slave (
    input  instr_valid, instr, imm, RD1, RD2,
    output instr_ready, RA1, RA2, RA3, WD3, WE3, result, zero, carry, done
  );
endinterface

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: 4-cycle read/exec/write sequencer driving a 4 x 8-bit register file
module regfile_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input logic           CLK,
  input logic           reset,
  regfile_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
  state_t            state_q, state_d;
  logic [7:0]        instr_q;
  logic [DATA_W-1:0] imm_q, op1_q, op2_q, result_q, result_d;
  logic [ADDR_W-1:0] ra1_q, ra2_q, ra3_q;
  logic              zero_q, carry_q, carry_d, accept;
  logic [DATA_W:0]   sum, diff;
  assign accept          = bus.instr_valid & bus.instr_ready;
  assign bus.instr_ready = (state_q == IDLE) & ~reset;
  assign bus.WE3         = ~((state_q == WRITE) & ~reset);
  assign bus.done        = (state_q == WRITE) & ~reset;
  assign bus.RA1         = ra1_q;
  assign bus.RA2         = ra2_q;
  assign bus.RA3         = ra3_q;
  assign bus.WD3         = result_q;
  assign bus.result      = result_q;
  assign bus.zero        = zero_q;
  assign bus.carry       = carry_q;
  // fixed IDLE -> READ -> EXEC -> WRITE ring, leaving IDLE only on an accepted instruction
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? READ : IDLE;
      READ:    state_d = EXEC;
      EXEC:    state_d = WRITE;
      default: state_d = IDLE;
    endcase
  end
  // ALU on latched operands; the extra top bit of sum/diff is carry-out or borrow
  always_comb begin
    sum      = {1'b0, op1_q} + {1'b0, op2_q};
    diff     = {1'b0, op1_q} - {1'b0, op2_q};
    result_d = instr_q[7:6] == 2'd0 ? imm_q :
               instr_q[7:6] == 2'd1 ? sum[DATA_W-1:0] :
               instr_q[7:6] == 2'd2 ? diff[DATA_W-1:0] : op1_q & op2_q;
    carry_d  = instr_q[7:6] == 2'd1 ? sum[DATA_W] :
               instr_q[7:6] == 2'd2 ? diff[DATA_W] : 1'b0;
  end
  // state register
  always_ff @(posedge CLK) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end
  // datapath latches: instruction at accept, operands after READ, result and write address after EXEC
  always_ff @(posedge CLK) begin
    if (reset) begin
      instr_q  <= '0;
      imm_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      ra1_q    <= '0;
      ra2_q    <= '0;
      ra3_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
    end else begin
      if (accept) begin
        instr_q <= bus.instr;
        imm_q   <= bus.imm;
        ra1_q   <= bus.instr[3:2];
        ra2_q   <= bus.instr[1:0];
      end
      if (state_q == READ) begin
        op1_q <= bus.RD1;
        op2_q <= bus.RD2;
      end
      if (state_q == EXEC) begin
        result_q <= result_d;
        zero_q   <= result_d == '0;
        carry_q  <= carry_d;
        ra3_q    <= instr_q[5:4];
      end
    end
  end
endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl: directed plus randomized checking of regfile_ctrl against a timeline model
module tb_regfile_ctrl;
  logic CLK = 1'b0;
  logic reset = 1'b1;
  regfile_ctrl_if #(.DATA_W(8), .ADDR_W(2)) bus ();
  regfile_ctrl #(.DATA_W(8), .ADDR_W(2)) dut (.CLK(CLK), .reset(reset), .bus(bus));
  always #5 CLK = ~CLK;

  logic [7:0] rf [4] = '{default: 8'h00};
  assign bus.RD1 = rf[bus.RA1];
  assign bus.RD2 = rf[bus.RA2];
  always @(posedge CLK) if (bus.WE3 === 1'b0) rf[bus.RA3] <= bus.WD3;

  int checks = 0;
  int errors = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic void alu(input logic [1:0] op, input int a, input int b, input int imm,
                              output int r, output bit c);
    case (op)
      2'd0:    begin r = imm;                 c = 0;         end
      2'd1:    begin r = (a + b) % 256;       c = (a + b) > 255; end
      2'd2:    begin r = (a - b + 256) % 256; c = a < b;     end
      default: begin r = a & b;               c = 0;         end
    endcase
  endfunction

  int         ph = 0;
  int         cyc = 0;
  bit         live = 0;
  int         m_pend;
  bit         m_pc;
  logic [1:0] m_rd, m_ra1, m_ra2, m_ra3;
  logic [7:0] m_res;
  logic       m_z, m_c;
  logic [7:0] mrf [4] = '{default: 8'h00};
  int         acc_q[$];
  int         we_lows = 0;

  // timeline model: an accepted instruction occupies four cycles; result visible from its last one
  always @(posedge CLK) begin
    cyc++;
    if (reset) begin
      ph = 0; m_res = 0; m_z = 1; m_c = 0; m_ra1 = 0; m_ra2 = 0; m_ra3 = 0; live = 1;
    end else if (live) begin
      if (ph == 0) begin
        if (bus.instr_valid) begin
          m_rd = bus.instr[5:4]; m_ra1 = bus.instr[3:2]; m_ra2 = bus.instr[1:0];
          alu(bus.instr[7:6], int'(mrf[bus.instr[3:2]]), int'(mrf[bus.instr[1:0]]), int'(bus.imm), m_pend, m_pc);
          acc_q.push_back(cyc);
          ph = 1;
        end
      end else if (ph == 2) begin
        m_res = 8'(m_pend); m_z = (m_pend == 0); m_c = m_pc; m_ra3 = m_rd; ph = 3;
      end else if (ph == 3) begin
        mrf[m_rd] = m_res; ph = 0;
      end else ph++;
    end
  end

  always @(negedge CLK) if (live) begin
    chk("instr_ready", bus.instr_ready, (ph == 0) && !reset);
    chk("done", bus.done, (ph == 3) && !reset);
    chk("WE3", bus.WE3, !((ph == 3) && !reset));
    chk("RA1", bus.RA1, m_ra1);
    chk("RA2", bus.RA2, m_ra2);
    if (ph == 3 || ph == 0) chk("RA3", bus.RA3, m_ra3);
    chk("WD3", bus.WD3, m_res);
    chk("result", bus.result, m_res);
    chk("zero", bus.zero, m_z);
    chk("carry", bus.carry, m_c);
    for (int i = 0; i < 4; i++) chk($sformatf("rf%0d", i), rf[i], mrf[i]);
    if (bus.WE3 === 1'b0) we_lows++;
  end

  task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [7:0] imm, input bit keep);
    int n = 0;
    bus.instr_valid = 1'b1;
    bus.instr = {op, rd, rs1, rs2};
    bus.imm = imm;
    do begin @(negedge CLK); n++; end while (bus.instr_ready !== 1'b1 && n < 20);
    chk("accept_wait", bus.instr_ready, 1);
    @(posedge CLK); #1;
    if (!keep) bus.instr_valid = 1'b0;
    bus.instr = 8'($urandom);
    bus.imm = 8'($urandom);
  endtask

  task automatic run(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                     input logic [1:0] rs2, input logic [7:0] imm);
    int w0 = we_lows;
    issue(op, rd, rs1, rs2, imm, 0);
    repeat (3) @(posedge CLK);
    #1;
    chk("we3_low_once", we_lows - w0, 1);
  endtask

  initial begin
    int a0, na;
    bus.instr_valid = 1'b0;
    bus.instr = 8'h00;
    bus.imm = 8'h00;
    repeat (2) @(posedge CLK);
    #1 reset = 1'b0;
    chk("rst_result", bus.result, 0);
    chk("rst_zero", bus.zero, 1);
    chk("rst_carry", bus.carry, 0);
    chk("rst_we3", bus.WE3, 1);
    run(2'd0, 2'd1, 2'd0, 2'd0, 8'h05);
    chk("ldi_r1", rf[1], 8'h05);
    chk("ldi_zero", bus.zero, 0);
    run(2'd0, 2'd2, 2'd0, 2'd0, 8'h03);
    chk("ldi_r2", rf[2], 8'h03);
    run(2'd0, 2'd1, 2'd0, 2'd0, 8'hFF);
    run(2'd0, 2'd2, 2'd0, 2'd0, 8'h02);
    run(2'd1, 2'd3, 2'd1, 2'd2, 8'h00);
    chk("add_r3", rf[3], 8'h01);
    chk("add_carry", bus.carry, 1);
    chk("add_zero", bus.zero, 0);
    run(2'd2, 2'd0, 2'd2, 2'd1, 8'h00);
    chk("sub_r0", rf[0], 8'h03);
    chk("sub_borrow", bus.carry, 1);
    run(2'd0, 2'd1, 2'd0, 2'd0, 8'h05);
    run(2'd2, 2'd3, 2'd1, 2'd1, 8'h00);
    chk("subself_r3", rf[3], 8'h00);
    chk("subself_zero", bus.zero, 1);
    chk("subself_carry", bus.carry, 0);
    run(2'd0, 2'd1, 2'd0, 2'd0, 8'h0F);
    run(2'd0, 2'd2, 2'd0, 2'd0, 8'hF0);
    run(2'd2, 2'd0, 2'd2, 2'd1, 8'h00);
    run(2'd3, 2'd0, 2'd1, 2'd2, 8'h00);
    chk("and_r0", rf[0], 8'h00);
    chk("and_zero", bus.zero, 1);
    a0 = acc_q.size();
    issue(2'd0, 2'd1, 2'd0, 2'd0, 8'h05, 1);
    issue(2'd1, 2'd1, 2'd1, 2'd1, 8'h00, 1);
    issue(2'd0, 2'd3, 2'd0, 2'd0, 8'h77, 0);
    repeat (3) @(posedge CLK);
    #1;
    chk("b2b_count", acc_q.size() - a0, 3);
    chk("b2b_gap1", acc_q[a0 + 1] - acc_q[a0], 4);
    chk("b2b_gap2", acc_q[a0 + 2] - acc_q[a0 + 1], 4);
    chk("hazard_r1", rf[1], 8'h0A);
    chk("b2b_r3", rf[3], 8'h77);
    na = acc_q.size();
    issue(2'd0, 2'd0, 2'd0, 2'd0, 8'h11, 0);
    for (int i = 0; i < 2; i++) begin
      bus.instr_valid = 1'($urandom);
      bus.instr = 8'($urandom);
      bus.imm = 8'($urandom);
      @(posedge CLK); #1;
    end
    bus.instr_valid = 1'b0;
    @(posedge CLK); #1;
    chk("busy_ignored_cnt", acc_q.size() - na, 1);
    chk("busy_ignored_r0", rf[0], 8'h11);
    run(2'd0, 2'd2, 2'd0, 2'd0, 8'h33);
    issue(2'd0, 2'd2, 2'd0, 2'd0, 8'hAA, 0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    reset = 1'b1;
    @(negedge CLK);
    chk("rstw_we3", bus.WE3, 1);
    chk("rstw_done", bus.done, 0);
    @(posedge CLK); #1;
    reset = 1'b0;
    @(negedge CLK);
    chk("rstw_r2", rf[2], 8'h33);
    chk("rstw_result", bus.result, 0);
    chk("rstw_zero", bus.zero, 1);
    chk("rstw_ready", bus.instr_ready, 1);
    chk("rstw_ra3", bus.RA3, 0);
    @(posedge CLK); #1;
    repeat (600) begin
      reset = ($urandom_range(0, 59) == 0);
      bus.instr_valid = 1'($urandom);
      bus.instr = 8'($urandom);
      bus.imm = 8'($urandom);
      @(posedge CLK); #1;
    end
    reset = 1'b0;
    bus.instr_valid = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
